// File: rtl/adjacency_pkg.sv
// Shared types and constants for the adjacency streamer: FSM states, table-write
// selectors and default widths of the node/edge tables.
package adjacency_pkg;

  localparam int unsigned NODE_IDX_W  = 10;
  localparam int unsigned COUNTER_W   = 4;
  localparam int unsigned EDGE_ADDR_W = 12;
  localparam int unsigned LOAD_DATA_W = 20;

  // Node table entry is {base, degree}
  localparam int unsigned NODE_ENTRY_W = EDGE_ADDR_W + COUNTER_W;

  localparam logic [NODE_IDX_W-1:0] NULL_IDX = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_START,
    ST_SEND_END,
    ST_REQ,
    ST_STREAM
  } state_e;

  typedef enum logic [1:0] {
    LD_NODE  = 2'b00,
    LD_EDGE  = 2'b01,
    LD_PAIR0 = 2'b10,
    LD_PAIR1 = 2'b11
  } load_sel_e;

endpackage

// File: rtl/adjacency_tables.sv
// Graph storage: node table {base, degree}, edge table {idx} and two start/end
// pairs, one write port, asynchronous reads.
module adjacency_tables
  import adjacency_pkg::*;
#(
  parameter int unsigned NODE_IDX_WIDTH  = NODE_IDX_W,
  parameter int unsigned COUNTER_WIDTH   = COUNTER_W,
  parameter int unsigned EDGE_ADDR_WIDTH = EDGE_ADDR_W,
  parameter int unsigned LOAD_DATA_WIDTH = LOAD_DATA_W
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  wr_en_i,
  input  logic [1:0]                            wr_sel_i,
  input  logic [EDGE_ADDR_WIDTH-1:0]            wr_addr_i,
  input  logic [LOAD_DATA_WIDTH-1:0]            wr_data_i,
  input  logic [NODE_IDX_WIDTH-1:0]             node_raddr_i,
  output logic [EDGE_ADDR_WIDTH-1:0]            node_base_o,
  output logic [COUNTER_WIDTH-1:0]              node_deg_o,
  input  logic [EDGE_ADDR_WIDTH-1:0]            edge_raddr_i,
  output logic [NODE_IDX_WIDTH-1:0]             edge_rdata_o,
  output logic [1:0][NODE_IDX_WIDTH-1:0]        pair_start_o,
  output logic [1:0][NODE_IDX_WIDTH-1:0]        pair_end_o
);

  localparam int unsigned NodeDepth  = 2 ** NODE_IDX_WIDTH;
  localparam int unsigned EdgeDepth  = 2 ** EDGE_ADDR_WIDTH;
  localparam int unsigned EntryWidth = EDGE_ADDR_WIDTH + COUNTER_WIDTH;

  // Packed arrays so a single reset clears every entry without a loop
  logic [NodeDepth-1:0][EntryWidth-1:0]     node_q;
  logic [EdgeDepth-1:0][NODE_IDX_WIDTH-1:0] edge_q;
  logic [1:0][NODE_IDX_WIDTH-1:0]           start_q;
  logic [1:0][NODE_IDX_WIDTH-1:0]           end_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      node_q  <= '0;
      edge_q  <= '0;
      start_q <= '0;
      end_q   <= '0;
    end else if (wr_en_i) begin
      case (wr_sel_i)
        LD_NODE:  node_q[wr_addr_i[NODE_IDX_WIDTH-1:0]] <= wr_data_i[EntryWidth-1:0];
        LD_EDGE:  edge_q[wr_addr_i] <= wr_data_i[NODE_IDX_WIDTH-1:0];
        LD_PAIR0: {start_q[0], end_q[0]} <= wr_data_i[2*NODE_IDX_WIDTH-1:0];
        default:  {start_q[1], end_q[1]} <= wr_data_i[2*NODE_IDX_WIDTH-1:0];
      endcase
    end
  end

  assign {node_base_o, node_deg_o} = node_q[node_raddr_i];
  assign edge_rdata_o              = edge_q[edge_raddr_i];
  assign pair_start_o              = start_q;
  assign pair_end_o                = end_q;

endmodule

// File: rtl/adjacency_streamer.sv
// Edge-list responder for the path-counting engine: sends the start/end pair,
// then streams each requested node's successors with a down-counter.
module adjacency_streamer
  import adjacency_pkg::*;
#(
  parameter int unsigned NODE_IDX_WIDTH  = NODE_IDX_W,
  parameter int unsigned COUNTER_WIDTH   = COUNTER_W,
  parameter int unsigned EDGE_ADDR_WIDTH = EDGE_ADDR_W,
  parameter int unsigned LOAD_DATA_WIDTH = LOAD_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_run,
  input  logic                       part_sel,
  input  logic                       done,
  input  logic [NODE_IDX_WIDTH-1:0]  node_idx,
  input  logic                       rd_next_node,
  output logic [NODE_IDX_WIDTH-1:0]  next_node_idx,
  output logic [COUNTER_WIDTH-1:0]   next_node_counter,
  output logic                       deg_err,
  input  logic                       load_en,
  input  logic [1:0]                 load_sel,
  input  logic [EDGE_ADDR_WIDTH-1:0] load_addr,
  input  logic [LOAD_DATA_WIDTH-1:0] load_data
);

  state_e                       state_q, state_d;
  logic [NODE_IDX_WIDTH-1:0]    idx_q, idx_d;
  logic [COUNTER_WIDTH-1:0]     cnt_q, cnt_d;
  logic                         deg_err_q, deg_err_d;
  logic [EDGE_ADDR_WIDTH-1:0]   eaddr_q, eaddr_d;
  logic                         sel_q, sel_d;

  logic [EDGE_ADDR_WIDTH-1:0]     node_base;
  logic [COUNTER_WIDTH-1:0]       node_deg;
  logic [EDGE_ADDR_WIDTH-1:0]     edge_raddr_c;
  logic [NODE_IDX_WIDTH-1:0]      edge_rdata;
  logic [1:0][NODE_IDX_WIDTH-1:0] pair_start;
  logic [1:0][NODE_IDX_WIDTH-1:0] pair_end;

  adjacency_tables #(
    .NODE_IDX_WIDTH  (NODE_IDX_WIDTH),
    .COUNTER_WIDTH   (COUNTER_WIDTH),
    .EDGE_ADDR_WIDTH (EDGE_ADDR_WIDTH),
    .LOAD_DATA_WIDTH (LOAD_DATA_WIDTH)
  ) u_tables (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en_i      (load_en),
    .wr_sel_i     (load_sel),
    .wr_addr_i    (load_addr),
    .wr_data_i    (load_data),
    .node_raddr_i (node_idx),
    .node_base_o  (node_base),
    .node_deg_o   (node_deg),
    .edge_raddr_i (edge_raddr_c),
    .edge_rdata_o (edge_rdata),
    .pair_start_o (pair_start),
    .pair_end_o   (pair_end)
  );

  // The first edge is read straight from the node base; later ones from the running pointer
  assign edge_raddr_c = (state_q == ST_REQ) ? node_base : eaddr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      deg_err_q <= 1'b0;
      eaddr_q   <= '0;
      sel_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      deg_err_q <= deg_err_d;
      eaddr_q   <= eaddr_d;
      sel_q     <= sel_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    deg_err_d = deg_err_q;
    eaddr_d   = eaddr_q;
    sel_d     = sel_q;
    if (load_en) begin
      state_d   = ST_IDLE;
      idx_d     = '0;
      cnt_d     = '0;
      deg_err_d = 1'b0;
    end else if (start_run) begin
      idx_d = '0;
      cnt_d = '0;
      if (done) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_d = ST_SEND_START;
            sel_d   = part_sel;
            idx_d   = pair_start[part_sel];
          end
          ST_SEND_START: begin
            state_d = ST_SEND_END;
            idx_d   = pair_end[sel_q];
          end
          ST_SEND_END: state_d = ST_REQ;
          ST_REQ: begin
            if (rd_next_node) begin
              state_d = ST_STREAM;
              if (node_deg == '0) begin
                // Degree-0 node: single NULL beat flagged as last
                deg_err_d = 1'b1;
                idx_d     = '1;
                cnt_d     = COUNTER_WIDTH'(1);
              end else begin
                idx_d   = edge_rdata;
                cnt_d   = node_deg;
                eaddr_d = node_base + EDGE_ADDR_WIDTH'(1);
              end
            end
          end
          ST_STREAM: begin
            if (cnt_q == COUNTER_WIDTH'(1)) begin
              state_d = ST_REQ;
            end else begin
              idx_d   = edge_rdata;
              cnt_d   = cnt_q - COUNTER_WIDTH'(1);
              eaddr_d = eaddr_q + EDGE_ADDR_WIDTH'(1);
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  assign next_node_idx     = idx_q;
  assign next_node_counter = cnt_q;
  assign deg_err           = deg_err_q;

endmodule

// File: tb/tb_adjacency_streamer.sv
// Scoreboard bench for adjacency_streamer: stimulus queues expected per-cycle
// outputs, a monitor pops and compares them one time unit after each rising edge.
module tb_adjacency_streamer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_run;
  logic        part_sel;
  logic        done;
  logic [9:0]  node_idx;
  logic        rd_next_node;
  logic [9:0]  next_node_idx;
  logic [3:0]  next_node_counter;
  logic        deg_err;
  logic        load_en;
  logic [1:0]  load_sel;
  logic [11:0] load_addr;
  logic [19:0] load_data;

  always #5 clk = ~clk;

  adjacency_streamer dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start_run         (start_run),
    .part_sel          (part_sel),
    .done              (done),
    .node_idx          (node_idx),
    .rd_next_node      (rd_next_node),
    .next_node_idx     (next_node_idx),
    .next_node_counter (next_node_counter),
    .deg_err           (deg_err),
    .load_en           (load_en),
    .load_sel          (load_sel),
    .load_addr         (load_addr),
    .load_data         (load_data)
  );

  typedef struct {
    int    cyc;
    int    idx;
    int    cnt;
    int    err;
    string nm;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input int eidx, input int ecnt, input int eerr);
    int aidx, acnt, aerr;
    aidx = int'(next_node_idx);
    acnt = int'(next_node_counter);
    aerr = int'(deg_err);
    checks++;
    if (aidx != eidx || acnt != ecnt || aerr != eerr) begin
      errors++;
      $display("FAIL %s @cycle %0d: got idx=%0d cnt=%0d err=%0d, expected idx=%0d cnt=%0d err=%0d",
               nm, cyc, aidx, acnt, aerr, eidx, ecnt, eerr);
    end
  endtask

  // Queue the outputs expected right after the coming rising edge, then advance
  task automatic beat(input int idx, input int cnt, input int err, input string nm);
    exp_t e;
    e.cyc = cyc + 1;
    e.idx = idx;
    e.cnt = cnt;
    e.err = err;
    e.nm  = nm;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic load(input logic [1:0] sel, input int addr, input int data);
    load_sel  = sel;
    load_addr = 12'(addr);
    load_data = 20'(data);
    load_en   = 1'b1;
    beat(0, 0, 0, "load");
    load_en   = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        if (e.cyc != cyc) begin
          checks++;
          errors++;
          $display("FAIL %s: expectation for cycle %0d not compared, now cycle %0d", e.nm, e.cyc, cyc);
        end else begin
          chk(e.nm, e.idx, e.cnt, e.err);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n        = 1'b0;
    start_run    = 1'b0;
    part_sel     = 1'b0;
    done         = 1'b0;
    node_idx     = '0;
    rd_next_node = 1'b0;
    load_en      = 1'b0;
    load_sel     = '0;
    load_addr    = '0;
    load_data    = '0;
    repeat (2) @(negedge clk);
    chk("reset_state", 0, 0, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Graph: pair0 {5,9}, node5 {0,2} -> 7,9; node7 {2,1} -> 9
    load(2'b10, 0, (5 << 10) | 9);
    load(2'b00, 5, (0 << 4) | 2);
    load(2'b01, 0, 7);
    load(2'b01, 1, 9);
    load(2'b00, 7, (2 << 4) | 1);
    load(2'b01, 2, 9);

    // Basic run
    start_run = 1'b1;
    part_sel  = 1'b0;
    beat(5, 0, 0, "basic_start");
    beat(9, 0, 0, "basic_end");
    beat(0, 0, 0, "basic_to_req");
    node_idx = 10'd5; rd_next_node = 1'b1;
    beat(7, 2, 0, "basic_n5_e0");
    rd_next_node = 1'b0;
    beat(9, 1, 0, "basic_n5_e1");
    beat(0, 0, 0, "basic_back_req");
    node_idx = 10'd7; rd_next_node = 1'b1;
    beat(9, 1, 0, "basic_n7_e0");
    rd_next_node = 1'b0;
    beat(0, 0, 0, "basic_req_again");
    beat(0, 0, 0, "basic_req_wait");

    // done from REQ, IDLE held, then resume from IDLE
    done = 1'b1;
    beat(0, 0, 0, "done_idle");
    beat(0, 0, 0, "done_hold");
    done = 1'b0;
    beat(5, 0, 0, "after_done_start");
    beat(9, 0, 0, "after_done_end");
    beat(0, 0, 0, "after_done_req");
    node_idx = 10'd5; rd_next_node = 1'b1;
    beat(7, 2, 0, "mid_e0");
    rd_next_node = 1'b0;
    done = 1'b1;
    beat(0, 0, 0, "done_mid_stream");
    beat(0, 0, 0, "done_mid_hold1");
    beat(0, 0, 0, "done_mid_hold2");
    start_run = 1'b0;
    done      = 1'b0;

    // Part select: pair1, part_sel change after the sample is ignored
    load(2'b11, 0, (3 << 10) | 4);
    start_run = 1'b1;
    part_sel  = 1'b1;
    beat(3, 0, 0, "part1_start");
    part_sel = 1'b0;
    beat(4, 0, 0, "part1_end");
    beat(0, 0, 0, "part1_req");
    done = 1'b1;
    beat(0, 0, 0, "part1_done");
    done = 1'b0;

    // Stall mid-stream
    beat(5, 0, 0, "stall_start");
    beat(9, 0, 0, "stall_end");
    beat(0, 0, 0, "stall_req");
    node_idx = 10'd5; rd_next_node = 1'b1;
    beat(7, 2, 0, "stall_e0");
    rd_next_node = 1'b0;
    start_run    = 1'b0;
    node_idx     = 10'd7;
    for (int i = 0; i < 3; i++) beat(7, 2, 0, "stall_hold");
    start_run = 1'b1;
    beat(9, 1, 0, "stall_resume");
    beat(0, 0, 0, "stall_back_req");

    // Degree-0 request, sticky error, cleared by a load that also forces IDLE
    node_idx = 10'd8; rd_next_node = 1'b1;
    beat(1023, 1, 1, "deg0_beat");
    rd_next_node = 1'b0;
    beat(0, 0, 1, "deg0_sticky1");
    beat(0, 0, 1, "deg0_sticky2");
    start_run = 1'b0;
    beat(0, 0, 1, "deg0_sticky_frozen");
    load(2'b01, 3, 0);
    start_run = 1'b1;
    beat(5, 0, 0, "load_forced_idle");
    start_run = 1'b0;

    // Edge address wrap: node10 {4095,2} -> edge[4095]=100, edge[0]=7
    load(2'b00, 10, (4095 << 4) | 2);
    load(2'b01, 4095, 100);
    start_run = 1'b1;
    beat(5, 0, 0, "wrap_start");
    beat(9, 0, 0, "wrap_end");
    beat(0, 0, 0, "wrap_req");
    node_idx = 10'd10; rd_next_node = 1'b1;
    beat(100, 2, 0, "wrap_e4095");
    rd_next_node = 1'b0;
    beat(7, 1, 0, "wrap_e0");
    beat(0, 0, 0, "wrap_back_req");
    start_run = 1'b0;

    // Max degree: node11 {16,15} -> edges 16..30 = 200..214
    load(2'b00, 11, (16 << 4) | 15);
    for (int k = 0; k < 15; k++) load(2'b01, 16 + k, 200 + k);
    start_run = 1'b1;
    beat(5, 0, 0, "maxdeg_start");
    beat(9, 0, 0, "maxdeg_end");
    beat(0, 0, 0, "maxdeg_req");
    node_idx = 10'd11; rd_next_node = 1'b1;
    for (int k = 0; k < 15; k++) begin
      beat(200 + k, 15 - k, 0, "maxdeg_beat");
      rd_next_node = 1'b0;
    end
    beat(0, 0, 0, "maxdeg_back_req");

    // Asynchronous reset mid-stream clears outputs, FSM and tables
    node_idx = 10'd11; rd_next_node = 1'b1;
    beat(200, 15, 0, "rst_pre_e0");
    rd_next_node = 1'b0;
    beat(201, 14, 0, "rst_pre_e1");
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset_now", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    beat(0, 0, 0, "post_rst_start_zero");
    beat(0, 0, 0, "post_rst_end_zero");
    beat(0, 0, 0, "post_rst_req");
    node_idx = 10'd5; rd_next_node = 1'b1;
    beat(1023, 1, 1, "post_rst_table_cleared");
    rd_next_node = 1'b0;
    start_run = 1'b0;

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
